// File: rtl/fm_sb_capture.sv
// ---------------------------------------------------------------------------
// fm_sb_capture
//
// Multi-channel spy buffer. Each channel records a stream of samples into its
// own circular memory. A rising edge on its freeze trigger starts a
// post-trigger window, and when that window ends the channel freezes. Frozen
// contents can then be read back one entry at a time through the shared
// readout port, or streamed out continuously on the playback port.
//
// Parameters
//   N_CH    number of independent channels
//   DATA_W  sample width
//   DEPTH   entries per channel (power of two); AW = log2(DEPTH)
//
// Ports
//   clk_hs, rst_hs   clock and asynchronous active-high reset
//   ch_valid/ch_data per-channel sample strobe and data (channel c at
//                    [c*DATA_W +: DATA_W])
//   freeze_req       per-channel freeze trigger (level; the rising edge acts)
//   post_trig        samples still captured after the trigger (all channels)
//   playback_mode    2 bits per channel: 00/11 capture, 01 single, 10 loop
//   rd_req/rd_ch/rd_addr         readout request (rd_addr 0 = oldest entry)
//   rd_valid/rd_err/rd_data      readout response
//   pb_valid/pb_data playback stream, packed like ch_data
//   frozen, wrapped  per-channel status
//   dbg_state        per-channel FSM state (2 bits each, state_e encoding)
//
// Handshake: there is no backpressure anywhere. Every rd_req is accepted on
// the clock edge that samples it, and rd_valid is high for exactly one cycle
// on the following cycle. A new request may be issued on every cycle.
// pb_valid marks each cycle that carries a playback entry. The consumer
// cannot stall the playback stream.
// ---------------------------------------------------------------------------
module fm_sb_capture #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int RCW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_hs,
    input  logic                   rst_hs,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        freeze_req,
    input  logic [AW-1:0]          post_trig,
    input  logic [N_CH*2-1:0]      playback_mode,
    input  logic                   rd_req,
    input  logic [RCW-1:0]         rd_ch,
    input  logic [AW-1:0]          rd_addr,
    output logic                   rd_valid,
    output logic                   rd_err,
    output logic [DATA_W-1:0]      rd_data,
    output logic [N_CH-1:0]        pb_valid,
    output logic [N_CH*DATA_W-1:0] pb_data,
    output logic [N_CH-1:0]        frozen,
    output logic [N_CH-1:0]        wrapped,
    output logic [N_CH*2-1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_CAPTURE  = 2'd0,
        ST_POST     = 2'd1,
        ST_FROZEN   = 2'd2,
        ST_PLAYBACK = 2'd3
    } state_e;

    localparam logic [1:0]    MODE_SINGLE = 2'b01;
    localparam logic [1:0]    MODE_LOOP   = 2'b10;
    localparam int            CW          = AW + 1;
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    // Per-channel readout results gathered for the shared response mux.
    logic [N_CH-1:0]        ch_rd_err;
    logic [N_CH*DATA_W-1:0] ch_rdata;

    genvar gc;
    generate
        for (gc = 0; gc < N_CH; gc++) begin : g_ch
            state_e            state_q, state_d;
            logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
            logic [AW-1:0]     post_cnt_q, post_cnt_d;
            logic [AW-1:0]     pb_ptr_q, pb_ptr_d;
            logic [CW-1:0]     pb_left_q, pb_left_d;
            logic              wrapped_q, wrapped_d;
            logic              pb_done_q, pb_done_d;
            logic              frz_prev_q;
            logic              pb_valid_q;
            logic [DATA_W-1:0] mem_q [DEPTH];
            logic [DATA_W-1:0] mem_rdata_q;

            logic              we;
            logic              pb_rd_en;
            logic              rd_hit;
            logic              frz_rise;
            logic              readable;
            logic              mode_cap;
            logic [1:0]        mode;
            logic [CW-1:0]     stored_cnt;
            logic [AW-1:0]     oldest;
            logic [AW-1:0]     rd_phys;
            logic [AW-1:0]     mem_raddr;

            assign mode       = playback_mode[2*gc +: 2];
            assign mode_cap   = (mode[0] == mode[1]);   // 00 and 11 both mean capture
            assign frz_rise   = freeze_req[gc] && !frz_prev_q;
            assign rd_hit     = rd_req && (rd_ch == RCW'(gc));
            assign stored_cnt = wrapped_q ? FULL_CNT : {1'b0, wr_ptr_q};
            assign oldest     = wrapped_q ? wr_ptr_q : '0;
            assign rd_phys    = oldest + rd_addr;        // wraps modulo DEPTH
            // Memory is frozen in both FROZEN and PLAYBACK, so both are readable.
            assign readable   = (state_q == ST_FROZEN) || (state_q == ST_PLAYBACK);

            // Next-state logic.
            always_comb begin
                state_d    = state_q;
                wr_ptr_d   = wr_ptr_q;
                wrapped_d  = wrapped_q;
                post_cnt_d = post_cnt_q;
                pb_ptr_d   = pb_ptr_q;
                pb_left_d  = pb_left_q;
                // A finished single playback stays finished until mode leaves 01.
                // Otherwise the channel would immediately start over.
                pb_done_d  = pb_done_q && (mode == MODE_SINGLE);
                we         = 1'b0;
                pb_rd_en   = 1'b0;

                case (state_q)
                    ST_CAPTURE: begin
                        if (frz_rise) begin
                            if (post_trig == '0) begin
                                // Freeze at once; the trigger-cycle sample is dropped.
                                state_d = ST_FROZEN;
                            end else begin
                                // The trigger-cycle sample is still a pre-trigger sample.
                                state_d    = ST_POST;
                                post_cnt_d = post_trig;
                                we         = ch_valid[gc];
                            end
                        end else begin
                            we = ch_valid[gc];
                        end
                    end

                    ST_POST: begin
                        if (ch_valid[gc]) begin
                            we         = 1'b1;
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == AW'(1)) begin
                                state_d = ST_FROZEN;
                            end
                        end
                    end

                    ST_FROZEN: begin
                        if ((mode == MODE_LOOP) || ((mode == MODE_SINGLE) && !pb_done_q)) begin
                            // An empty buffer has nothing to play, so the channel stays here.
                            if (stored_cnt != '0) begin
                                state_d   = ST_PLAYBACK;
                                pb_ptr_d  = oldest;
                                pb_left_d = stored_cnt;
                            end
                        end else if (mode_cap && !freeze_req[gc]) begin
                            state_d    = ST_CAPTURE;
                            wr_ptr_d   = '0;
                            wrapped_d  = 1'b0;
                            post_cnt_d = '0;
                        end
                    end

                    ST_PLAYBACK: begin
                        if (mode_cap) begin
                            // Any entry already in flight still comes out next cycle.
                            state_d = ST_FROZEN;
                        end else if (!rd_hit) begin
                            // A readout on this channel takes the read port, and playback waits.
                            pb_rd_en  = 1'b1;
                            pb_ptr_d  = pb_ptr_q + 1'b1;
                            pb_left_d = pb_left_q - 1'b1;
                            if (pb_left_q == CW'(1)) begin
                                if (mode == MODE_LOOP) begin
                                    pb_ptr_d  = oldest;
                                    pb_left_d = stored_cnt;
                                end else begin
                                    state_d   = ST_FROZEN;
                                    pb_done_d = 1'b1;
                                end
                            end
                        end
                    end

                    default: state_d = ST_CAPTURE;
                endcase

                if (we) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wrapped_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_hs or posedge rst_hs) begin
                if (rst_hs) begin
                    state_q    <= ST_CAPTURE;
                    wr_ptr_q   <= '0;
                    wrapped_q  <= 1'b0;
                    post_cnt_q <= '0;
                    pb_ptr_q   <= '0;
                    pb_left_q  <= '0;
                    pb_done_q  <= 1'b0;
                    frz_prev_q <= 1'b0;
                    pb_valid_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    wr_ptr_q   <= wr_ptr_d;
                    wrapped_q  <= wrapped_d;
                    post_cnt_q <= post_cnt_d;
                    pb_ptr_q   <= pb_ptr_d;
                    pb_left_q  <= pb_left_d;
                    pb_done_q  <= pb_done_d;
                    frz_prev_q <= freeze_req[gc];
                    pb_valid_q <= pb_rd_en;
                end
            end

            // Sample storage. It is not reset; only the pointers are.
            always_ff @(posedge clk_hs) begin
                if (we) begin
                    mem_q[wr_ptr_q] <= ch_data[gc*DATA_W +: DATA_W];
                end
            end

            // There is one read port per channel, and readout takes priority over playback.
            assign mem_raddr = rd_hit ? rd_phys : pb_ptr_q;

            always_ff @(posedge clk_hs) begin
                mem_rdata_q <= mem_q[mem_raddr];
            end

            assign ch_rd_err[gc]               = !readable || ({1'b0, rd_addr} >= stored_cnt);
            assign ch_rdata[gc*DATA_W +: DATA_W] = mem_rdata_q;
            // The read register is not reset, so the valid flag gates it to zero.
            assign pb_valid[gc]                = pb_valid_q;
            assign pb_data[gc*DATA_W +: DATA_W]  = pb_valid_q ? mem_rdata_q : '0;
            assign frozen[gc]                  = readable;
            assign wrapped[gc]                 = wrapped_q;
            assign dbg_state[2*gc +: 2]        = state_q;
        end
    endgenerate

    // Shared readout response.
    logic           rd_valid_q;
    logic           rd_err_q;
    logic [RCW-1:0] rd_ch_q;
    logic           rd_err_sel;

    // A channel number past N_CH matches no channel and keeps the error set.
    always_comb begin
        rd_err_sel = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch == RCW'(c)) begin
                rd_err_sel = ch_rd_err[c];
            end
        end
    end

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            rd_valid_q <= rd_req;
            rd_err_q   <= rd_req && rd_err_sel;
            if (rd_req) begin
                rd_ch_q <= rd_ch;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid_q && !rd_err_q) begin
            for (int c = 0; c < N_CH; c++) begin
                if (rd_ch_q == RCW'(c)) begin
                    rd_data = ch_rdata[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: doc/fm_sb_capture.md
FM_SB_CAPTURE -- requirements
Module: fm_sb_capture

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent spy channels.
REQ-002 SHALL have parameter DATA_W, default 64, sample width in bits.
REQ-003 SHALL have parameter DEPTH, default 512, entries per channel, power of two; AW = log2(DEPTH).
REQ-004 SHALL have port clk_hs  in  1  single clock for all logic.
REQ-005 SHALL have port rst_hs  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ch_valid  in  N_CH  per-channel sample strobe.
REQ-007 SHALL have port ch_data  in  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port freeze_req  in  N_CH  per-channel freeze trigger, level.
REQ-009 SHALL have port post_trig  in  AW  samples still captured after the trigger, shared by all channels.
REQ-010 SHALL have port playback_mode  in  N_CH*2  per channel: 00 capture, 01 single playback, 10 loop playback, 11 treated as 00.
REQ-011 SHALL have port rd_req, rd_ch (log2 N_CH, min 1), rd_addr (AW)  in  readout request, channel, logical address (0 = oldest).
REQ-012 SHALL have port rd_valid, rd_err (1), rd_data (DATA_W)  out  readout response.
REQ-013 SHALL have port pb_valid (N_CH), pb_data (N_CH*DATA_W)  out  playback stream, same packing as ch_data.
REQ-014 SHALL have port frozen, wrapped (N_CH)  out  per-channel status.

Function
REQ-015 SHALL give each channel a state machine with states CAPTURE, POST, FROZEN, PLAYBACK.
REQ-016 In CAPTURE, SHALL write ch_data into memory at wr_ptr on every ch_valid and increment wr_ptr modulo DEPTH; wrapped SHALL set when wr_ptr wraps from DEPTH-1 to 0.
REQ-017 Going from CAPTURE to POST SHALL happen on a rising freeze_req; the post counter SHALL load post_trig.
REQ-018 If post_trig = 0, CAPTURE SHALL go directly to FROZEN; the triggering-cycle sample SHALL NOT be written.
REQ-019 In POST, each ch_valid SHALL write a sample and decrement the counter; the write that makes the counter 0 SHALL move the channel to FROZEN.
REQ-020 If the post window exceeds the remaining space, POST SHALL keep wrapping (oldest data overwritten).
REQ-021 In FROZEN, SHALL perform no writes; frozen=1; ch_valid SHALL be ignored.
REQ-022 Going from FROZEN to CAPTURE SHALL happen when freeze_req=0 and playback_mode is 00 or 11; wr_ptr, wrapped and the counter SHALL clear.
REQ-023 Going from FROZEN to PLAYBACK SHALL happen when playback_mode is 01 or 10.
REQ-024 In PLAYBACK, SHALL output one entry per cycle on pb_data with pb_valid=1, starting at the oldest entry (wr_ptr if wrapped, else 0).
REQ-025 PLAYBACK length SHALL be DEPTH entries if wrapped, else wr_ptr entries.
REQ-026 Mode 01 SHALL return to FROZEN after the last entry; mode 10 SHALL restart at the oldest entry with no gap cycle.
REQ-027 A mode change to 00 during PLAYBACK SHALL return the channel to FROZEN after the current entry.
REQ-028 Playback with zero stored entries SHALL emit nothing and stay in FROZEN.
REQ-029 Readout: rd_req samples rd_ch and rd_addr; rd_valid SHALL pulse exactly 1 cycle later.
REQ-030 Readout physical address SHALL be (oldest + rd_addr) mod DEPTH.
REQ-031 If the channel is not FROZEN, rd_addr ≥ the stored count, or rd_ch ≥ N_CH, rd_err SHALL be 1 and rd_data SHALL be 0.
REQ-032 Back-to-back rd_req SHALL be accepted every cycle.
REQ-033 Readout SHALL have priority over playback for the memory read port; the playback pointer SHALL stall that cycle with pb_valid=0.
REQ-034 Channels SHALL be fully independent except for the shared readout port and post_trig.

Reset
REQ-035 On rst_hs=1, SHALL immediately force all channels to CAPTURE and clear wr_ptr, counters, wrapped, frozen, pb_valid, pb_data, rd_valid, rd_err and rd_data to 0.
REQ-036 Reset mid-POST or mid-PLAYBACK SHALL abort it; memory contents need not be cleared.
REQ-037 After deassertion, the first ch_valid SHALL write address 0.

Verification
REQ-038 Write 10 samples 1..10, freeze with post_trig=0, read addr 0..9 -> data 1..10, rd_err=0; read addr 10 -> rd_err=1, rd_data=0.
REQ-039 DEPTH=8: write 1..11, freeze with post_trig=0 -> wrapped=1; addr 0 = 4, addr 7 = 11.
REQ-040 Trigger after sample 5 with post_trig=3 -> frozen after sample 8; samples 9+ are ignored; addr 7 = 8.
REQ-041 Frozen with 4 entries, mode 10 -> pb_data 1,2,3,4,1,2… continuously; switch to 01 -> stops after 4, pb_valid=0.
REQ-042 rd_req on a channel in CAPTURE -> rd_err=1; rd_req during playback -> one pb_valid=0 bubble, no lost entry.
REQ-043 Assert rst_hs mid-POST -> all outputs 0 in the same cycle; the next write goes to address 0.
